// File: rtl/axi_video_pkg.sv
// Shared types for the AXI-Stream video source: test-pattern selector and source FSM states.
// Latency: n/a (types only).
// Backpressure: n/a.
package axi_video_pkg;

    typedef enum logic [1:0] {
        BARS  = 2'd0,
        RAMP  = 2'd1,
        SOLID = 2'd2,
        COUNT = 2'd3
    } pattern_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        GAP    = 2'd2
    } src_state_e;

endpackage

// File: rtl/axi_video_pattern_gen.sv
// Registered test-pattern pixel for one beat, computed from (mode, x, bar index, beat index, solid colour).
// Latency: pixel_o updates on the edge where adv_i is high, from the coordinates presented that cycle.
// Backpressure: holds pixel_o while adv_i is low.
// Ports: clk, rst_n (async active-low), adv_i load strobe, mode_i, x_i, bar_i, beat_i, solid_i, pixel_o.
module axi_video_pattern_gen
    import axi_video_pkg::*;
#(
    parameter int DATA_WIDTH = 24,
    parameter int XW         = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  adv_i,
    input  pattern_e              mode_i,
    input  logic [XW-1:0]         x_i,
    input  logic [2:0]            bar_i,
    input  logic [DATA_WIDTH-1:0] beat_i,
    input  logic [DATA_WIDTH-1:0] solid_i,
    output logic [DATA_WIDTH-1:0] pixel_o
);
    localparam int C = DATA_WIDTH / 3;

    logic [DATA_WIDTH-1:0] pixel_d, pixel_q;
    logic [2:0]            code;
    logic [C-1:0]          ramp;

    always_comb begin
        // Bar 0 maps to code 7 (white), bar 7 to code 0 (black).
        code    = 3'd7 - bar_i;
        ramp    = C'(x_i);
        pixel_d = '0;
        case (mode_i)
            BARS:    pixel_d = {{C{code[2]}}, {C{code[1]}}, {C{code[0]}}};
            RAMP:    pixel_d = {ramp, ramp, ramp};
            SOLID:   pixel_d = solid_i;
            COUNT:   pixel_d = beat_i;
            default: pixel_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_q <= '0;
        end else if (adv_i) begin
            pixel_q <= pixel_d;
        end
    end

    assign pixel_o = pixel_q;

endmodule

// File: rtl/axi_stream_video_source.sv
// AXI-Stream raster frame source (H_ACTIVE x V_ACTIVE beats, SOF on tuser, tlast per line or per frame).
// Latency: first beat valid one cycle after enable is sampled in IDLE; one beat per cycle, GAP_CYCLES idle between frames.
// Backpressure: all output registers and counters hold while tvalid & !tready; tvalid never depends on tready.
// Ports: clk, rst_n, enable, pattern_sel, solid_color, m_axis_* (tdata/tvalid/tlast/tuser out, tready in), busy, frame_done, frame_count.
module axi_stream_video_source
    import axi_video_pkg::*;
#(
    parameter int DATA_WIDTH = 24,
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int GAP_CYCLES = 16,
    parameter int TLAST_EOF  = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [1:0]            pattern_sel,
    input  logic [DATA_WIDTH-1:0] solid_color,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    input  logic                  m_axis_tready,
    output logic                  busy,
    output logic                  frame_done,
    output logic [31:0]           frame_count
);
    localparam int XW      = $clog2(H_ACTIVE);
    localparam int YW      = $clog2(V_ACTIVE + 1);
    localparam int BAR_LEN = H_ACTIVE / 8;
    localparam int BCW     = (BAR_LEN > 1) ? $clog2(BAR_LEN) : 1;
    localparam int GW      = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [XW-1:0]  X_LAST   = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0]  Y_LAST   = YW'(V_ACTIVE - 1);
    localparam logic [BCW-1:0] BAR_LAST = BCW'(BAR_LEN - 1);
    localparam logic [GW-1:0]  GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    src_state_e            state_q, state_d;
    // x/y/bar/beat counters hold the coordinates of the NEXT beat to load into the output registers.
    logic [XW-1:0]         x_q, x_d;
    logic [YW-1:0]         y_q, y_d;
    logic [2:0]            bar_q, bar_d;
    logic [BCW-1:0]        barc_q, barc_d;
    logic [DATA_WIDTH-1:0] beat_q, beat_d;
    logic [GW-1:0]         gap_q, gap_d;
    pattern_e              sel_q, sel_d;
    logic [DATA_WIDTH-1:0] solid_q, solid_d;
    logic                  tvalid_q, tvalid_d;
    logic                  tlast_q, tlast_d;
    logic                  tuser_q, tuser_d;
    logic                  eof_q, eof_d;     // beat on the bus is the final beat of the frame
    logic                  fdone_q, fdone_d;
    logic [31:0]           fcount_q, fcount_d;

    logic                  hs, load, restart;
    logic [XW-1:0]         cx;
    logic [YW-1:0]         cy;
    logic [2:0]            cbar;
    logic [BCW-1:0]        cbarc;
    logic [DATA_WIDTH-1:0] cbeat;
    pattern_e              gen_mode;
    logic [DATA_WIDTH-1:0] gen_solid;

    assign hs = m_axis_tvalid & m_axis_tready;

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        bar_d    = bar_q;
        barc_d   = barc_q;
        beat_d   = beat_q;
        gap_d    = gap_q;
        sel_d    = sel_q;
        solid_d  = solid_q;
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        tuser_d  = tuser_q;
        eof_d    = eof_q;
        fdone_d  = 1'b0;
        fcount_d = fcount_q;
        load     = 1'b0;
        restart  = 1'b0;   // load beat 0 of a new frame from live pattern inputs this cycle

        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = ACTIVE;
                    sel_d   = pattern_e'(pattern_sel);
                    solid_d = solid_color;
                    x_d     = '0;
                    y_d     = '0;
                    bar_d   = '0;
                    barc_d  = '0;
                    beat_d  = '0;
                end
            end
            ACTIVE: begin
                if (!tvalid_q) begin
                    // First cycle after leaving IDLE: prime the output registers with beat 0.
                    load = 1'b1;
                end else if (hs) begin
                    if (eof_q) begin
                        fcount_d = fcount_q + 32'd1;
                        fdone_d  = 1'b1;
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                        tuser_d  = 1'b0;
                        eof_d    = 1'b0;
                        if (GAP_CYCLES != 0) begin
                            state_d = GAP;
                            gap_d   = '0;
                        end else if (enable) begin
                            restart = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        load = 1'b1;
                    end
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    if (enable) begin
                        restart = 1'b1;
                        state_d = ACTIVE;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        cx        = restart ? '0 : x_q;
        cy        = restart ? '0 : y_q;
        cbar      = restart ? '0 : bar_q;
        cbarc     = restart ? '0 : barc_q;
        cbeat     = restart ? '0 : beat_q;
        gen_mode  = restart ? pattern_e'(pattern_sel) : sel_q;
        gen_solid = restart ? solid_color : solid_q;

        if (load || restart) begin
            tvalid_d = 1'b1;
            tuser_d  = (cx == '0) && (cy == '0);
            tlast_d  = (cx == X_LAST) && ((TLAST_EOF == 0) || (cy == Y_LAST));
            eof_d    = (cx == X_LAST) && (cy == Y_LAST);
            beat_d   = cbeat + DATA_WIDTH'(1);
            if (cx == X_LAST) begin
                x_d    = '0;
                y_d    = cy + YW'(1);
                bar_d  = '0;
                barc_d = '0;
            end else begin
                x_d = cx + XW'(1);
                y_d = cy;
                if (cbarc == BAR_LAST) begin
                    barc_d = '0;
                    bar_d  = cbar + 3'd1;
                end else begin
                    barc_d = cbarc + BCW'(1);
                    bar_d  = cbar;
                end
            end
            if (restart) begin
                sel_d   = gen_mode;
                solid_d = gen_solid;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            x_q      <= '0;
            y_q      <= '0;
            bar_q    <= '0;
            barc_q   <= '0;
            beat_q   <= '0;
            gap_q    <= '0;
            sel_q    <= BARS;
            solid_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            tuser_q  <= 1'b0;
            eof_q    <= 1'b0;
            fdone_q  <= 1'b0;
            fcount_q <= '0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            bar_q    <= bar_d;
            barc_q   <= barc_d;
            beat_q   <= beat_d;
            gap_q    <= gap_d;
            sel_q    <= sel_d;
            solid_q  <= solid_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            tuser_q  <= tuser_d;
            eof_q    <= eof_d;
            fdone_q  <= fdone_d;
            fcount_q <= fcount_d;
        end
    end

    axi_video_pattern_gen #(
        .DATA_WIDTH (DATA_WIDTH),
        .XW         (XW)
    ) u_pattern (
        .clk     (clk),
        .rst_n   (rst_n),
        .adv_i   (load | restart),
        .mode_i  (gen_mode),
        .x_i     (cx),
        .bar_i   (cbar),
        .beat_i  (cbeat),
        .solid_i (gen_solid),
        .pixel_o (m_axis_tdata)
    );

    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tuser  = tuser_q;
    assign busy          = (state_q != IDLE);
    assign frame_done    = fdone_q;
    assign frame_count   = fcount_q;

endmodule

// File: tb/tb_axi_stream_video_source.sv
module tb_axi_stream_video_source;

    localparam int HA = 16;
    localparam int VA = 3;
    localparam int NA = HA * VA;
    localparam int HB = 8;

    logic        clk;
    logic        rst_n;

    logic        en_a, tready_a, tvalid_a, tlast_a, tuser_a, busy_a, fdone_a;
    logic [1:0]  sel_a;
    logic [23:0] solid_a, tdata_a;
    logic [31:0] fcount_a;

    logic        en_b, tready_b, tvalid_b, tlast_b, tuser_b, busy_b, fdone_b;
    logic [1:0]  sel_b;
    logic [23:0] solid_b, tdata_b;
    logic [31:0] fcount_b;

    int total;
    int bad;
    int exp_fc_a;
    int exp_fc_b;

    axi_stream_video_source #(
        .DATA_WIDTH(24), .H_ACTIVE(HA), .V_ACTIVE(VA), .GAP_CYCLES(3), .TLAST_EOF(0)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .enable(en_a), .pattern_sel(sel_a), .solid_color(solid_a),
        .m_axis_tdata(tdata_a), .m_axis_tvalid(tvalid_a), .m_axis_tlast(tlast_a),
        .m_axis_tuser(tuser_a), .m_axis_tready(tready_a), .busy(busy_a),
        .frame_done(fdone_a), .frame_count(fcount_a)
    );

    axi_stream_video_source #(
        .DATA_WIDTH(24), .H_ACTIVE(HB), .V_ACTIVE(1), .GAP_CYCLES(0), .TLAST_EOF(1)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .enable(en_b), .pattern_sel(sel_b), .solid_color(solid_b),
        .m_axis_tdata(tdata_b), .m_axis_tvalid(tvalid_b), .m_axis_tlast(tlast_b),
        .m_axis_tuser(tuser_b), .m_axis_tready(tready_b), .busy(busy_b),
        .frame_done(fdone_b), .frame_count(fcount_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference pixel for frame-local beat index idx on a line of h beats.
    function automatic logic [23:0] exp_pix(input int mode, input logic [23:0] solid,
                                            input int idx, input int h);
        int         x;
        logic [2:0] k;
        logic [7:0] c;
        x = idx % h;
        k = 3'(7 - x / (h / 8));
        c = 8'(x);
        case (mode)
            0:       exp_pix = {{8{k[2]}}, {8{k[1]}}, {8{k[0]}}};
            1:       exp_pix = {c, c, c};
            2:       exp_pix = solid;
            default: exp_pix = 24'(idx);
        endcase
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        en_a = 1'b0; sel_a = 2'd0; solid_a = '0; tready_a = 1'b0;
        en_b = 1'b0; sel_b = 2'd0; solid_b = '0; tready_b = 1'b0;
        exp_fc_a = 0;
        exp_fc_b = 0;
        repeat (3) @(negedge clk);
        total++;
        if ({tvalid_a, tlast_a, tuser_a, busy_a, fdone_a} !== 5'b0) begin
            bad++;
            $display("FAIL reset_ctl_a got=%b want=00000", {tvalid_a, tlast_a, tuser_a, busy_a, fdone_a});
        end
        total++;
        if (tdata_a !== 24'h0 || fcount_a !== 32'd0) begin
            bad++;
            $display("FAIL reset_data_a tdata=%h fcount=%0d want 0/0", tdata_a, fcount_a);
        end
        total++;
        if ({tvalid_b, tlast_b, tuser_b, busy_b, fdone_b} !== 5'b0 || tdata_b !== 24'h0 || fcount_b !== 32'd0) begin
            bad++;
            $display("FAIL reset_b ctl=%b tdata=%h fcount=%0d want all 0",
                     {tvalid_b, tlast_b, tuser_b, busy_b, fdone_b}, tdata_b, fcount_b);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_start_bars();
        int idx, cyc, first_cyc, last_cyc;
        logic stayed_low;
        idx = 0; cyc = 0; first_cyc = -1; last_cyc = -1;
        @(negedge clk);
        sel_a = 2'd0; tready_a = 1'b1; en_a = 1'b1;
        @(negedge clk);
        en_a = 1'b0;
        total++;
        if (tvalid_a !== 1'b0) begin
            bad++;
            $display("FAIL start_latency_early tvalid=%b want=0", tvalid_a);
        end
        while (idx < NA && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (tvalid_a) begin
                if (idx == 0) first_cyc = cyc;
                total++;
                if (tdata_a !== exp_pix(0, 24'h0, idx, HA)) begin
                    bad++;
                    $display("FAIL bars_data beat=%0d got=%h want=%h", idx, tdata_a, exp_pix(0, 24'h0, idx, HA));
                end
                total++;
                if (tuser_a !== (idx == 0) || tlast_a !== ((idx % HA) == HA - 1)) begin
                    bad++;
                    $display("FAIL bars_flags beat=%0d tuser=%b tlast=%b want %b/%b",
                             idx, tuser_a, tlast_a, (idx == 0), ((idx % HA) == HA - 1));
                end
                idx++;
                if (idx == NA) last_cyc = cyc;
            end
        end
        total++;
        if (idx != NA || first_cyc != 1 || last_cyc != NA) begin
            bad++;
            $display("FAIL bars_timing beats=%0d first=%0d last=%0d want %0d/1/%0d", idx, first_cyc, last_cyc, NA, NA);
        end
        exp_fc_a++;
        @(negedge clk);
        total++;
        if (fdone_a !== 1'b1 || fcount_a !== 32'(exp_fc_a)) begin
            bad++;
            $display("FAIL frame_done_pulse fdone=%b fcount=%0d want 1/%0d", fdone_a, fcount_a, exp_fc_a);
        end
        @(negedge clk);
        stayed_low = 1'b1;
        total++;
        if (fdone_a !== 1'b0) begin
            bad++;
            $display("FAIL frame_done_width fdone=%b want=0", fdone_a);
        end
        repeat (10) begin
            if (tvalid_a !== 1'b0) stayed_low = 1'b0;
            @(negedge clk);
        end
        total++;
        if (stayed_low !== 1'b1 || busy_a !== 1'b0) begin
            bad++;
            $display("FAIL after_frame_idle tvalid_low=%b busy=%b want 1/0", stayed_low, busy_a);
        end
    endtask

    task automatic test_backpressure();
        int idx, cyc;
        logic held;
        logic [23:0] pd;
        logic pl, pu;
        idx = 0; cyc = 0; held = 1'b0; pd = '0; pl = 1'b0; pu = 1'b0;
        @(negedge clk);
        sel_a = 2'd3; en_a = 1'b1;
        @(negedge clk);
        en_a = 1'b0;
        while (idx < NA && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (held) begin
                total++;
                if ({tvalid_a, tdata_a, tlast_a, tuser_a} !== {1'b1, pd, pl, pu}) begin
                    bad++;
                    $display("FAIL bp_stable beat=%0d got=%b/%h/%b/%b want 1/%h/%b/%b",
                             idx, tvalid_a, tdata_a, tlast_a, tuser_a, pd, pl, pu);
                end
            end
            tready_a = ($urandom_range(0, 2) != 0);
            if (tvalid_a && tready_a) begin
                total++;
                if (tdata_a !== 24'(idx) || tuser_a !== (idx == 0) || tlast_a !== ((idx % HA) == HA - 1)) begin
                    bad++;
                    $display("FAIL bp_beat idx=%0d got=%h/%b/%b want %h/%b/%b", idx, tdata_a, tuser_a, tlast_a,
                             24'(idx), (idx == 0), ((idx % HA) == HA - 1));
                end
                idx++;
                held = 1'b0;
            end else if (tvalid_a) begin
                held = 1'b1; pd = tdata_a; pl = tlast_a; pu = tuser_a;
            end else begin
                held = 1'b0;
            end
        end
        if (idx != NA) begin
            total++; bad++;
            $display("FAIL bp_timeout beats=%0d want=%0d", idx, NA);
        end
        exp_fc_a++;
        tready_a = 1'b1;
        repeat (8) @(negedge clk);
        total++;
        if (fcount_a !== 32'(exp_fc_a) || busy_a !== 1'b0) begin
            bad++;
            $display("FAIL bp_count fcount=%0d busy=%b want %0d/0", fcount_a, busy_a, exp_fc_a);
        end
    endtask

    task automatic test_continuous();
        int idx, cyc, lowrun, f, mode, want_low;
        logic [23:0] s1;
        idx = 0; cyc = 0; lowrun = 0;
        s1 = 24'($urandom);
        @(negedge clk);
        sel_a = 2'd1; solid_a = ~s1; tready_a = 1'b1; en_a = 1'b1;
        while (idx < 3 * NA && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            if (tvalid_a) begin
                if (idx > 0) begin
                    want_low = ((idx % NA) == 0) ? 3 : 0;
                    total++;
                    if (lowrun != want_low) begin
                        bad++;
                        $display("FAIL cont_gap beat=%0d low_cycles=%0d want=%0d", idx, lowrun, want_low);
                    end
                end
                f = idx / NA;
                mode = (f < 2) ? 1 : 2;
                total++;
                if (tdata_a !== exp_pix(mode, s1, idx % NA, HA) || tuser_a !== ((idx % NA) == 0)) begin
                    bad++;
                    $display("FAIL cont_data frame=%0d beat=%0d got=%h/%b want %h/%b", f, idx % NA, tdata_a, tuser_a,
                             exp_pix(mode, s1, idx % NA, HA), ((idx % NA) == 0));
                end
                idx++;
                lowrun = 0;
                if (idx == NA + 20) begin sel_a = 2'd2; solid_a = s1; end
                if (idx == 2 * NA + 10) en_a = 1'b0;
            end else if (idx > 0) begin
                lowrun++;
            end
        end
        if (idx != 3 * NA) begin
            total++; bad++;
            $display("FAIL cont_timeout beats=%0d want=%0d", idx, 3 * NA);
        end
        exp_fc_a += 3;
        repeat (8) @(negedge clk);
        total++;
        if (fcount_a !== 32'(exp_fc_a) || busy_a !== 1'b0) begin
            bad++;
            $display("FAIL cont_count fcount=%0d busy=%b want %0d/0", fcount_a, busy_a, exp_fc_a);
        end
    endtask

    task automatic test_eof_single_line();
        int idx, cyc, lowrun, dones;
        idx = 0; cyc = 0; lowrun = 0; dones = 0;
        @(negedge clk);
        sel_b = 2'd3; tready_b = 1'b1; en_b = 1'b1;
        while (cyc < 600) begin
            @(negedge clk);
            cyc++;
            if (fdone_b) dones++;
            if (!en_b && !busy_b) break;
            if (idx >= 16) tready_b = 1'($urandom_range(0, 1));
            if (tvalid_b && tready_b) begin
                total++;
                if (tdata_b !== 24'(idx % HB) || tuser_b !== ((idx % HB) == 0) || tlast_b !== ((idx % HB) == HB - 1)) begin
                    bad++;
                    $display("FAIL eof_beat idx=%0d got=%h/%b/%b want %h/%b/%b", idx, tdata_b, tuser_b, tlast_b,
                             24'(idx % HB), ((idx % HB) == 0), ((idx % HB) == HB - 1));
                end
                if (idx > 0 && idx < 16) begin
                    total++;
                    if (lowrun != 0) begin
                        bad++;
                        $display("FAIL b2b_gap beat=%0d low_cycles=%0d want=0", idx, lowrun);
                    end
                end
                idx++;
                lowrun = 0;
                if (idx == 28) en_b = 1'b0;
            end else if (!tvalid_b) begin
                lowrun++;
            end
        end
        if (cyc >= 600) begin
            total++; bad++;
            $display("FAIL eof_timeout beats=%0d", idx);
        end
        exp_fc_b += 4;
        total++;
        if (idx != 32 || dones != 4 || fcount_b !== 32'(exp_fc_b)) begin
            bad++;
            $display("FAIL eof_totals beats=%0d dones=%0d fcount=%0d want 32/4/%0d", idx, dones, fcount_b, exp_fc_b);
        end
        tready_b = 1'b1;
    endtask

    task automatic test_reset_midframe();
        int seen, cyc, idx, first_cyc;
        seen = 0; cyc = 0; idx = 0; first_cyc = -1;
        @(negedge clk);
        sel_a = 2'd3; tready_a = 1'b1; en_a = 1'b1;
        while (cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (tvalid_a) begin
                if (seen == 5) break;
                seen++;
            end
        end
        total++;
        if (seen != 5) begin
            bad++;
            $display("FAIL rst_mid_reach beats_seen=%0d want=5", seen);
        end
        rst_n = 1'b0;
        exp_fc_a = 0;
        exp_fc_b = 0;
        #1;
        total++;
        if ({tvalid_a, tlast_a, tuser_a, busy_a, fdone_a} !== 5'b0 || tdata_a !== 24'h0 || fcount_a !== 32'd0) begin
            bad++;
            $display("FAIL rst_mid_clear ctl=%b tdata=%h fcount=%0d want all 0",
                     {tvalid_a, tlast_a, tuser_a, busy_a, fdone_a}, tdata_a, fcount_a);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        while (idx < NA && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (tvalid_a) begin
                if (idx == 0) begin
                    first_cyc = cyc;
                    en_a = 1'b0;
                    total++;
                    if (tuser_a !== 1'b1) begin
                        bad++;
                        $display("FAIL rst_restart_sof tuser=%b want=1", tuser_a);
                    end
                end
                total++;
                if (tdata_a !== 24'(idx)) begin
                    bad++;
                    $display("FAIL rst_restart_data beat=%0d got=%h want=%h", idx, tdata_a, 24'(idx));
                end
                idx++;
            end
        end
        total++;
        if (idx != NA || first_cyc != 2) begin
            bad++;
            $display("FAIL rst_restart_timing beats=%0d first=%0d want %0d/2", idx, first_cyc, NA);
        end
        exp_fc_a++;
        @(negedge clk);
        total++;
        if (fcount_a !== 32'(exp_fc_a)) begin
            bad++;
            $display("FAIL rst_restart_count fcount=%0d want=%0d", fcount_a, exp_fc_a);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_start_bars();
        test_backpressure();
        test_continuous();
        test_eof_single_line();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
